// File: rtl/key_emu_pkg.sv
// Shared types and constants for the mechanical key emulator.
// Holds the FSM state encoding and the LFSR tap definition.
package key_emu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        SETTLE
    } state_e;

    localparam int LFSR_W = 16;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s
    );
        logic [LFSR_W-1:0] r;
        r = s >> 1;
        if (s[0]) begin
            r = r ^ LFSR_MASK;
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR.
// Steps on every clock edge once out of reset.
module lfsr16
    import key_emu_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic [LFSR_W-1:0] q_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/key_bounce_gen.sv
// Emulated mechanical push-button: turns clean press/release commands
// into a bursty, pseudo-random bouncing line followed by a settle period.
module key_bounce_gen
    import key_emu_pkg::*;
#(
    parameter logic              KEY_ACTIVE = 1'b0,
    parameter int                BOUNCE_N   = 5,
    parameter int                GAP_W      = 8,
    parameter int                SETTLE_CYC = 1000,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic cmd_valid_i,
    input  logic cmd_press_i,
    output logic ready_o,
    output logic key_o,
    output logic pressed_o,
    output logic done_o
);

    localparam int GW = GAP_W + 1;
    localparam int EW = $clog2(BOUNCE_N + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    localparam logic [GW-1:0] GAP_ONE   = GW'(1);
    localparam logic [EW-1:0] EDGE_ONE  = EW'(1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(BOUNCE_N - 1);
    localparam logic [SW-1:0] SET_ONE   = SW'(1);
    localparam logic [SW-1:0] SET_LOAD  = SW'(SETTLE_CYC);

    if (BOUNCE_N < 1 || (BOUNCE_N % 2) == 0) begin : g_bad_bounce
        $error("BOUNCE_N must be odd and >= 1");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("SETTLE_CYC must be >= 1");
    end
    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end
    if (GAP_W < 1 || GAP_W > LFSR_W) begin : g_bad_gap
        $error("GAP_W must be in 1..16");
    end

    logic [LFSR_W-1:0] lfsr;
    logic              lfsr_unused;
    logic [GW-1:0]     gap_now;
    logic              target;

    state_e        state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [EW-1:0] edge_cnt_q, edge_cnt_d;
    logic [SW-1:0] set_cnt_q, set_cnt_d;
    logic          hold_q, hold_d;
    logic          key_q, key_d;
    logic          pressed_q, pressed_d;
    logic          done_q, done_d;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .q_o     (lfsr)
    );

    assign lfsr_unused = ^(lfsr >> GAP_W);
    assign gap_now     = {1'b0, lfsr[GAP_W-1:0]} + GAP_ONE;
    assign target      = cmd_press_i ? KEY_ACTIVE : ~KEY_ACTIVE;

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        edge_cnt_d = edge_cnt_q;
        set_cnt_d  = set_cnt_q;
        hold_d     = hold_q;
        key_d      = key_q;
        pressed_d  = pressed_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    pressed_d = cmd_press_i;
                    if (target != key_q) begin
                        state_d    = BOUNCE;
                        gap_cnt_d  = gap_now;
                        edge_cnt_d = '0;
                    end else begin
                        // extra hold cycle keeps same-level latency at SETTLE_CYC+1
                        state_d   = SETTLE;
                        set_cnt_d = SET_LOAD;
                        hold_d    = 1'b1;
                    end
                end
            end
            BOUNCE: begin
                if (gap_cnt_q == GAP_ONE) begin
                    key_d      = ~key_q;
                    edge_cnt_d = edge_cnt_q + EDGE_ONE;
                    gap_cnt_d  = gap_now;
                    if (edge_cnt_q == EDGE_LAST) begin
                        state_d   = SETTLE;
                        set_cnt_d = SET_LOAD;
                        hold_d    = 1'b0;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
            SETTLE: begin
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    set_cnt_d = set_cnt_q - SET_ONE;
                    if (set_cnt_q == SET_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            gap_cnt_q  <= '0;
            edge_cnt_q <= '0;
            set_cnt_q  <= '0;
            hold_q     <= 1'b0;
            key_q      <= ~KEY_ACTIVE;
            pressed_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            set_cnt_q  <= set_cnt_d;
            hold_q     <= hold_d;
            key_q      <= key_d;
            pressed_q  <= pressed_d;
            done_q     <= done_d;
        end
    end

    assign ready_o   = (state_q == IDLE);
    assign key_o     = key_q;
    assign pressed_o = pressed_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Scoreboard bench for key_bounce_gen: commands push predicted edges
// and done pulses; a negedge monitor pops and compares them.
module tb_key_bounce_gen;

    localparam int N  = 5;
    localparam int GW = 3;
    localparam int S  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_press = 1'b0;
    logic ready, key, pressed, done;

    always #5 clk = ~clk;

    key_bounce_gen #(
        .KEY_ACTIVE (1'b0),
        .BOUNCE_N   (N),
        .GAP_W      (GW),
        .SETTLE_CYC (S),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_press_i (cmd_press),
        .ready_o     (ready),
        .key_o       (key),
        .pressed_o   (pressed),
        .done_o      (done)
    );

    int total = 0;
    int bad = 0;

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        logic [15:0] r;
        r = {1'b0, s[15:1]};
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // reference LFSR and edge counter, both reset with the DUT
    logic [15:0] mlfsr;
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mlfsr <= 16'hACE1;
            cyc <= 0;
        end else begin
            mlfsr <= ref_step(mlfsr);
            cyc <= cyc + 1;
        end
    end

    typedef struct {
        bit   is_done;
        int   at;
        logic lvl;
    } ev_t;

    ev_t evq[$];
    ev_t me;
    logic mkey = 1'b1;
    logic prev_key;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: event at cyc %0d with empty queue, key=%0d",
                 name, cyc, key);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_key = key;
        end else begin
            if (key !== prev_key) begin
                if (evq.size() == 0) begin
                    unexpected("stray_edge");
                end else begin
                    me = evq.pop_front();
                    chk("edge_kind", 32'(me.is_done), 0);
                    chk("edge_cycle", cyc, me.at);
                    chk("edge_level", 32'(key), 32'(me.lvl));
                end
            end
            if (done) begin
                if (evq.size() == 0) begin
                    unexpected("stray_done");
                end else begin
                    me = evq.pop_front();
                    chk("done_kind", 32'(me.is_done), 1);
                    chk("done_cycle", cyc, me.at);
                    chk("done_level", 32'(key), 32'(me.lvl));
                    chk("done_ready", 32'(ready), 1);
                end
            end
            prev_key = key;
        end
    end

    task automatic issue(input logic press);
        logic tgt, lv;
        logic [15:0] l;
        int t, g;
        @(negedge clk);
        tgt = press ? 1'b0 : 1'b1;
        t = cyc + 1;
        l = mlfsr;
        if (tgt != mkey) begin
            lv = mkey;
            for (int i = 0; i < N; i++) begin
                g = int'(l[2:0]) + 1;
                for (int j = 0; j < g; j++) l = ref_step(l);
                t += g;
                lv = ~lv;
                evq.push_back('{1'b0, t, lv});
            end
            evq.push_back('{1'b1, t + S, tgt});
        end else begin
            evq.push_back('{1'b1, t + S + 1, tgt});
        end
        mkey = tgt;
        cmd_valid = 1'b1;
        cmd_press = press;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pressed_after_accept", 32'(pressed), 32'(press));
        chk("ready_drops", 32'(ready), 0);
    endtask

    task automatic wait_q(input int lvl);
        for (int i = 0; i < 600 && evq.size() > lvl; i++) @(negedge clk);
        if (evq.size() > lvl) begin
            total++;
            bad++;
            $display("FAIL wait_timeout: queue %0d want <= %0d",
                     evq.size(), lvl);
            evq.delete();
        end
    endtask

    initial begin
        #12;
        chk("rst_key", 32'(key), 1);
        chk("rst_pressed", 32'(pressed), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("lfsr_seq", 32'(dut.u_lfsr.q_o), 32'(mlfsr));
        end

        issue(1'b1);
        wait_q(0);
        chk("press_final", 32'(key), 0);

        issue(1'b0);
        wait_q(0);
        chk("release_final", 32'(key), 1);

        issue(1'b0);
        wait_q(0);
        chk("same_level_key", 32'(key), 1);
        chk("same_level_pressed", 32'(pressed), 0);

        issue(1'b1);
        wait_q(4);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_press = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_pressed", 32'(pressed), 1);
        wait_q(0);
        chk("busy_final_key", 32'(key), 0);
        chk("busy_final_pressed", 32'(pressed), 1);

        issue(1'b0);
        wait_q(0);
        chk("release2_final", 32'(key), 1);

        issue(1'b1);
        wait_q(4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_key", 32'(key), 1);
        chk("midrst_pressed", 32'(pressed), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_ready", 32'(ready), 1);
        evq.delete();
        mkey = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("post_rst_idle_key", 32'(key), 1);

        issue(1'b1);
        wait_q(0);
        chk("post_rst_press", 32'(key), 0);
        chk("post_rst_pressed", 32'(pressed), 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
